// File: rtl/ex_mul_unit_if.sv
// Operand/result bundle between the ID/EX register, the EX multiplier and EX/MEM.
// master = ID/EX side driving the command, slave = the multiply unit.
interface ex_mul_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             acc_in;
    logic             s_in;
    logic [3:0]       status_in;
    logic [3:0]       dest_in;
    logic [WIDTH-1:0] val_rn_in;
    logic [WIDTH-1:0] val_rm_in;
    logic [WIDTH-1:0] val_acc_in;

    logic             stall;
    logic             result_valid;
    logic [WIDTH-1:0] result_out;
    logic [3:0]       dest_out;
    logic             wb_en_out;
    logic             s_out;
    logic [3:0]       status_out;

    modport master (
        output start, acc_in, s_in, status_in, dest_in,
        output val_rn_in, val_rm_in, val_acc_in,
        input  stall, result_valid, result_out, dest_out,
        input  wb_en_out, s_out, status_out
    );

    modport slave (
        input  start, acc_in, s_in, status_in, dest_in,
        input  val_rn_in, val_rm_in, val_acc_in,
        output stall, result_valid, result_out, dest_out,
        output wb_en_out, s_out, status_out
    );
endinterface

// File: rtl/ex_mul_unit.sv
// Iterative MUL/MLA engine for the EX stage; BITS_PER_CYCLE multiplier bits per step.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module ex_mul_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ex_mul_unit_if.slave  bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] partial;
    logic [3:0]       dest_q;
    logic             s_q;
    logic [1:0]       cv_q;
    logic             run_last;

    logic [WIDTH-1:0] result_q;
    logic [3:0]       dest_out_q;
    logic [3:0]       status_out_q;
    logic             valid_q;
    logic             s_out_q;

    always_comb begin
        partial = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (mplier_q[b]) begin
                partial = partial + (mcand_q << b);
            end
        end
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
    end

`ifdef MUL_EARLY_TERM_EN
    assign run_last = (cnt_q == '0) || (mplier_d == '0);
`else
    assign run_last = (cnt_q == '0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            dest_q       <= '0;
            s_q          <= 1'b0;
            cv_q         <= '0;
            result_q     <= '0;
            dest_out_q   <= '0;
            status_out_q <= '0;
            valid_q      <= 1'b0;
            s_out_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            s_out_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            state_q  <= RUN;
                            cnt_q    <= CW'(N - 1);
                            mcand_q  <= bus.val_rn_in;
                            mplier_q <= bus.val_rm_in;
                            acc_q    <= bus.acc_in ? bus.val_acc_in : '0;
                            dest_q   <= bus.dest_in;
                            s_q      <= bus.s_in;
                            cv_q     <= bus.status_in[1:0];
                        end
                    end
                    RUN: begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                        if (run_last) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    DONE: begin
                        state_q      <= IDLE;
                        result_q     <= acc_q;
                        dest_out_q   <= dest_q;
                        status_out_q <= {acc_q[WIDTH-1],
                                         acc_q == '0, cv_q};
                        valid_q      <= 1'b1;
                        s_out_q      <= s_q;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Combinational so the front end freezes in the same cycle start is seen
    assign bus.stall = ((state_q == IDLE) && bus.start && !flush)
                     || (state_q == RUN);

    assign bus.result_valid = valid_q;
    assign bus.wb_en_out    = valid_q;
    assign bus.result_out   = result_q;
    assign bus.dest_out     = dest_out_q;
    assign bus.status_out   = status_out_q;
    assign bus.s_out        = s_out_q;
endmodule
